// File: rtl/ps2_kbd_ctrl_if.sv
// Key-event stream between the PS/2 controller and its CPU-side consumer.
// Latency: n/a (wires only).
// Backpressure: valid/ready; the head event is held until evt_ready is seen with evt_valid.
interface ps2_kbd_ctrl_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_release;
    logic       evt_ext;

    // Producer side (the controller)
    modport master (
        output evt_valid,
        output evt_code,
        output evt_release,
        output evt_ext,
        input  evt_ready
    );

    // Consumer side (device/MMIO logic)
    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_release,
        input  evt_ext,
        output evt_ready
    );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receive path: deframe, check, merge E0/F0 prefixes into key events, queue them.
// Latency: event pushed 1 cycle after the stop-bit fall; evt_valid rises 2 cycles after that fall.
// Backpressure: FWFT queue; a push into a full queue with no pop is dropped and sets sticky overflow.
module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    input  logic           clr_overflow,
    output logic           overflow,
    output logic           frame_err,
    ps2_kbd_ctrl_if.master evt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {IDLE, RECV} fstate_t;
    typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dstate_t;

    typedef struct packed {
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } evt_t;

    // ---------------- synchronisers ----------------
    logic [2:0] clk_s;
    logic [1:0] dat_s;
    logic       fall;
    logic       dbit;

    // Both lines reset to the idle-high level so reset release never looks like an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s <= 3'b111;
            dat_s <= 2'b11;
        end else begin
            clk_s <= {clk_s[1:0], ps2_clk};
            dat_s <= {dat_s[0], ps2_data};
        end
    end

    assign fall = clk_s[2] & ~clk_s[1];
    assign dbit = dat_s[1];

    // ---------------- frame FSM ----------------
    fstate_t        fs, fs_nxt;
    logic [3:0]     bit_idx;
    logic [9:0]     shreg;       // start, data[7:0], parity; stop is taken live from dbit
    logic [TW-1:0]  tcnt;
    logic           frame_done;
    logic           frame_ok;
    logic           tmo;
    logic           byte_vld;
    logic [7:0]     byte_dat;

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fs <= IDLE;
        else     fs <= fs_nxt;
    end

    // Frame next-state: a fall always wins over a timeout in the same cycle
    always_comb begin
        fs_nxt     = fs;
        frame_done = 1'b0;
        tmo        = 1'b0;
        case (fs)
            IDLE: begin
                if (fall) fs_nxt = RECV;
            end
            RECV: begin
                if (fall && bit_idx == 4'd10) begin
                    fs_nxt     = IDLE;
                    frame_done = 1'b1;
                end else if (!fall && tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    fs_nxt = IDLE;
                    tmo    = 1'b1;
                end
            end
            default: fs_nxt = IDLE;
        endcase
    end

    // Odd parity over data+parity, start low, stop high
    assign frame_ok = ~shreg[0] & dbit & (^shreg[9:1]);

    // Bit capture, timeout counter and the one-cycle byte/error strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx   <= 4'd0;
            shreg     <= '0;
            tcnt      <= '0;
            byte_vld  <= 1'b0;
            byte_dat  <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            if (fall) begin
                if (bit_idx != 4'd10) shreg[bit_idx] <= dbit;
                bit_idx <= frame_done ? 4'd0 : bit_idx + 4'd1;
            end else if (tmo) begin
                bit_idx <= 4'd0;
            end

            if (fall || fs != RECV || tmo) tcnt <= '0;
            else                           tcnt <= tcnt + 1'b1;

            byte_vld  <= frame_done & frame_ok;
            frame_err <= (frame_done & ~frame_ok) | tmo;
            if (frame_done) byte_dat <= shreg[8:1];
        end
    end

    // ---------------- scancode decoder ----------------
    dstate_t ds, ds_nxt;
    logic    push;
    evt_t    push_ent;

    // Decoder state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ds <= D_IDLE;
        else     ds <= ds_nxt;
    end

    // Prefix tracking; any rejected frame throws away pending prefixes
    always_comb begin
        ds_nxt   = ds;
        push     = 1'b0;
        push_ent = '{code: byte_dat, rel: 1'b0, ext: 1'b0};
        if (frame_err) begin
            ds_nxt = D_IDLE;
        end else if (byte_vld) begin
            if (byte_dat == 8'hE0) begin
                ds_nxt = D_EXT;
            end else if (byte_dat == 8'hF0) begin
                ds_nxt = (ds == D_EXT || ds == D_EXT_BRK) ? D_EXT_BRK : D_BRK;
            end else begin
                push         = 1'b1;
                push_ent.rel = (ds == D_BRK) || (ds == D_EXT_BRK);
                push_ent.ext = (ds == D_EXT) || (ds == D_EXT_BRK);
                ds_nxt       = D_IDLE;
            end
        end
    end

    // ---------------- event FIFO ----------------
    evt_t        mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, wr_en, drop;
    evt_t        head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = ~empty & evt.evt_ready;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    // Storage needs no reset: outputs are gated by empty
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_ent;
    end

    // Pointers and sticky overflow; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    assign head            = mem[rd_ptr[AW-1:0]];
    assign evt.evt_valid   = ~empty;
    assign evt.evt_code    = empty ? 8'h00 : head.code;
    assign evt.evt_release = ~empty & head.rel;
    assign evt.evt_ext     = ~empty & head.ext;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: directed PS/2 frames, expected events queued and checked by a monitor.
module tb_ps2_kbd_ctrl;
    localparam int TMO = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic clr_overflow = 1'b0;
    logic overflow;
    logic frame_err;

    ps2_kbd_ctrl_if evt_if ();

    ps2_kbd_ctrl #(.FIFO_DEPTH(8), .TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .clr_overflow (clr_overflow),
        .overflow     (overflow),
        .frame_err    (frame_err),
        .evt          (evt_if.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int err_seen = 0;
    logic [9:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: counts frame_err cycles and checks every consumed event against the queue
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) err_seen++;
            if (evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_evt: got %0h want none",
                             {evt_if.evt_code, evt_if.evt_release, evt_if.evt_ext});
                end else begin
                    e = exp_q.pop_front();
                    chk("evt", {22'd0, evt_if.evt_code, evt_if.evt_release, evt_if.evt_ext}, {22'd0, e});
                end
            end
        end
    end

    // One PS/2 bit; mode 1 checks evt_valid timing around the stop fall, mode 2 pulses ready on the push cycle
    task automatic ps2_bit(input logic b, input int mode);
        @(posedge clk); #2;
        ps2_data = b;
        repeat (4) @(posedge clk);
        #2;
        ps2_clk = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #2;
            if (mode == 1) begin
                if (i == 3) chk("lat_pre",  evt_if.evt_valid, 1'b0);
                if (i == 4) chk("lat_rise", evt_if.evt_valid, 1'b1);
                if (i == 5) chk("lat_pop",  evt_if.evt_valid, 1'b0);
            end else if (mode == 2) begin
                if (i == 3) evt_if.evt_ready = 1'b1;
                if (i == 4) evt_if.evt_ready = 1'b0;
            end
        end
        ps2_clk = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                              input int nbits, input int mode);
        logic [10:0] f;
        f = {stop, (~^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], (i == 10) ? mode : 0);
        repeat (6) @(posedge clk);
        #2;
    endtask

    task automatic good(input logic [7:0] d);
        send_frame(d, 1'b0, 1'b1, 11, 0);
    endtask

    task automatic drain(input string nm);
        int n;
        evt_if.evt_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        repeat (3) @(posedge clk);
        #2;
        chk(nm, exp_q.size(), 0);
        chk({nm, "_empty"}, {evt_if.evt_valid, evt_if.evt_code, evt_if.evt_release, evt_if.evt_ext}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        evt_if.evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_outs", {evt_if.evt_valid, evt_if.evt_code, evt_if.evt_release, evt_if.evt_ext,
                         overflow, frame_err}, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("rst_after", {evt_if.evt_valid, frame_err}, 0);

        // Plain make code with latency check
        exp_q.push_back({8'h1C, 1'b0, 1'b0});
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1);
        drain("make_1c");

        // Break code
        exp_q.push_back({8'h1C, 1'b1, 1'b0});
        good(8'hF0); good(8'h1C);
        drain("brk_1c");

        // Extended break, then extended make
        exp_q.push_back({8'h75, 1'b1, 1'b1});
        good(8'hE0); good(8'hF0); good(8'h75);
        exp_q.push_back({8'h75, 1'b0, 1'b1});
        good(8'hE0); good(8'h75);
        drain("ext_75");

        // Bad parity, bad stop, prefix dropped by error
        send_frame(8'h1C, 1'b1, 1'b1, 11, 0);
        chk("err_parity", err_seen, 1);
        send_frame(8'h1C, 1'b0, 1'b0, 11, 0);
        chk("err_stop", err_seen, 2);
        exp_q.push_back({8'h1C, 1'b0, 1'b0});
        good(8'hF0);
        send_frame(8'h33, 1'b1, 1'b1, 11, 0);
        good(8'h1C);
        chk("err_prefix", err_seen, 3);
        drain("prefix_drop");

        // Overflow: 9 codes into an 8-deep queue with no consumer
        evt_if.evt_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) exp_q.push_back({8'(k), 1'b0, 1'b0});
            good(8'(k));
            if (k == 8) chk("ovf_at_full", overflow, 1'b0);
        end
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_valid", evt_if.evt_valid, 1'b1);
        clr_overflow = 1'b1;
        @(posedge clk); #2;
        clr_overflow = 1'b0;
        chk("ovf_clr", overflow, 1'b0);
        drain("ovf_drain");

        // Full queue: push and pop in the same cycle
        evt_if.evt_ready = 1'b0;
        for (int k = 0; k < 9; k++) exp_q.push_back({8'h11 + 8'(k), 1'b0, 1'b0});
        for (int k = 0; k < 8; k++) good(8'h11 + 8'(k));
        send_frame(8'h19, 1'b0, 1'b1, 11, 2);
        chk("full_pushpop_ovf", overflow, 1'b0);
        drain("full_pushpop");

        // Timeout after a partial frame
        send_frame(8'hAA, 1'b0, 1'b1, 5, 0);
        repeat (TMO + 20) @(posedge clk);
        #2;
        chk("err_timeout", err_seen, 4);
        exp_q.push_back({8'h29, 1'b0, 1'b0});
        good(8'h29);
        drain("after_tmo");

        // Reset mid-frame with queued events
        evt_if.evt_ready = 1'b0;
        for (int k = 0; k < 3; k++) good(8'h40 + 8'(k));
        chk("pre_rst_valid", evt_if.evt_valid, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1, 4, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("mid_rst_valid", {evt_if.evt_valid, overflow, frame_err}, 0);
        rst = 1'b0;
        repeat (TMO + 20) @(posedge clk);
        #2;
        chk("post_rst_quiet", {evt_if.evt_valid, frame_err}, 0);
        chk("post_rst_noerr", err_seen, 4);
        evt_if.evt_ready = 1'b1;
        exp_q.push_back({8'h5A, 1'b0, 1'b0});
        good(8'h5A);
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
- Keyboard-side controller for the PS/2 receive path. Deframes 11-bit PS/2 frames, checks them, and sequences multi-byte scancodes (E0/F0 prefixes) into single key events.
- Queues events in a small FIFO with a valid/ready interface toward the CPU-side device/MMIO logic.
- Replaces the display-only receive loop with a consumable, error-aware event stream.

Parameters:
- FIFO_DEPTH, 8, event queue entries; power of 2, minimum 2.
- TIMEOUT_CYC, 50000, clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock (asynchronous)
- ps2_data  in  1  raw PS/2 data (asynchronous)
- evt_ready  in  1  consumer accepts head event
- evt_valid  out  1  FIFO non-empty
- evt_code  out  8  scancode of head event
- evt_release  out  1  head event is a break (key up)
- evt_ext  out  1  head event carried E0 prefix
- clr_overflow  in  1  clears overflow
- overflow  out  1  sticky: an event was dropped
- frame_err  out  1  one-cycle pulse per rejected frame

Behaviour:
- Reset: all outputs 0, FIFO empty, both FSMs idle, timeout counter 0. ps2_clk and ps2_data synchronisers reset to 1 (idle line), so no spurious edge follows reset.
- Sync: ps2_clk passes through 3 flops. fall = s[2] & ~s[1]. ps2_data passes through 2 flops, and the synced data bit is sampled on the cycle fall=1.
- Frame FSM states: IDLE, RECV.
  - IDLE: a fall moves to RECV with bit index 1, storing bit0 (start).
  - RECV: each fall stores bit[idx] and increments idx. The fall that stores bit 10 (stop) ends the frame and returns to IDLE.
  - Frame valid iff start=0, stop=1, and XOR(data[7:0], parity)=1 (odd parity).
  - On a valid frame, the byte goes to the decoder on the next cycle.
  - On an invalid frame, frame_err=1 for exactly that next cycle and the byte is discarded.
- Timeout: the counter clears on every fall and counts while in RECV. When it reaches TIMEOUT_CYC-1, the FSM aborts to IDLE, frame_err pulses for 1 cycle, and the partial frame is discarded.
- Decoder FSM states: D_IDLE, D_EXT, D_BRK, D_EXT_BRK. Transitions per received byte:
  - E0 in any state -> D_EXT.
  - F0 in D_IDLE or D_BRK -> D_BRK.
  - F0 in D_EXT or D_EXT_BRK -> D_EXT_BRK.
  - Any other byte emits {code, release = state in {D_BRK, D_EXT_BRK}, ext = state in {D_EXT, D_EXT_BRK}}, then -> D_IDLE.
  - Prefix bytes never emit an event.
  - frame_err (parity/stop/timeout) forces the decoder to D_IDLE.
- Latency: the event is pushed 1 cycle after the stop-bit fall cycle. evt_valid rises on the following cycle, i.e. 2 cycles after the stop-bit fall.
- FIFO: first-word fall-through. evt_* outputs are driven from the head entry; pop occurs when evt_valid & evt_ready.
  - evt_code/evt_release/evt_ext are 0 when empty.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty are derived from the MSB.
- Boundaries:
  - Push while full with no pop: the new event is dropped and overflow is set.
  - Push and pop in the same cycle while full: both succeed; count is unchanged and no overflow.
  - Push and pop in the same cycle while empty: the push is stored and evt_valid rises next cycle; no bypass path.
  - overflow stays set until clr_overflow. If a clear coincides with a new drop, overflow remains 1.
- Reset mid-frame or with a non-empty FIFO: everything is discarded immediately, with no event or frame_err after deassertion.

Test Plan:
- Frame 0x1C, start 0, data LSB-first, parity 0, stop 1 -> evt_valid 2 cycles after the stop fall, code=0x1C, release=0, ext=0. With evt_ready=1, evt_valid drops the next cycle.
- Frames F0,1C -> exactly one event: code=0x1C, release=1, ext=0.
- Frames E0,F0,75 -> one event: code=0x75, release=1, ext=1. Frames E0,75 -> code=0x75, release=0, ext=1.
- Frame 0x1C with parity 1 -> frame_err high for 1 cycle, no event. Next, frame with stop=0 -> frame_err again. Then F0, bad frame, 1C -> code=0x1C, release=0 (prefix dropped).
- evt_ready=0 while sending 9 make codes 0x01..0x09 with FIFO_DEPTH=8 -> 8 events 0x01..0x08 in order, overflow=1. Then fill to full, send one frame while asserting evt_ready on the push cycle -> no overflow, count stays 8. clr_overflow -> overflow=0.
- 5 bits of a frame, then idle for TIMEOUT_CYC cycles -> frame_err pulse, then a good 0x29 frame decodes. Assert rst mid-frame with 3 events queued -> evt_valid=0, and the next full frame decodes cleanly.
